// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Time-multiplexed scan driver for a single shared hex-to-
//                7-segment decoder. Holds a NUM_DIGITS-nibble display word,
//                presents one digit per slot with an active-low anode select
//                and guard cycles against ghosting. Word updates are staged
//                and committed only at frame boundaries (no tearing).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    update_i,
    output logic [3:0]              nibble_o,
    output logic [NUM_DIGITS-1:0]   anode_no,
    output logic                    frame_done_o
);

    localparam int c_tick_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w  = $clog2(NUM_DIGITS);

    localparam logic [c_tick_w-1:0]   c_tick_last = c_tick_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
    // One extra bit so a guard length equal to 2**c_tick_w still compares correctly
    localparam logic [c_tick_w:0]     c_guard     = (c_tick_w + 1)'(GUARD_CYCLES);
    localparam logic [NUM_DIGITS-1:0] c_one       = NUM_DIGITS'(1);

    logic [c_tick_w-1:0]     r_tick;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_staging;
    logic [NUM_DIGITS-1:0]   r_staging_en;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_en;
    logic                    r_pending;

    logic                    w_tick_wrap;
    logic                    w_boundary;
    logic                    w_in_guard;
    logic [3:0]              w_digits [NUM_DIGITS];
    logic [3:0]              w_nibble;
    logic [NUM_DIGITS-1:0]   w_anode_n;

    assign w_tick_wrap = (r_tick == c_tick_last);
    assign w_boundary  = w_tick_wrap && (r_idx == c_idx_last);
    assign w_in_guard  = ({1'b0, r_tick} < c_guard);

    // Split the displayed word into one nibble per digit position
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign w_digits[g] = r_shadow[4*g +: 4];
    end

    assign w_nibble  = w_digits[r_idx];
    assign w_anode_n = (w_in_guard || !r_shadow_en[r_idx]) ? '1 : ~(c_one << r_idx);

    // Slot timer and digit index; idx wraps explicitly so unused codes never occur
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tick <= '0;
            r_idx  <= '0;
        end else if (w_tick_wrap) begin
            r_tick <= '0;
            r_idx  <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // Stage host writes and commit them to the shadow word only at frame boundaries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_staging    <= '0;
            r_staging_en <= '0;
            r_shadow     <= '0;
            r_shadow_en  <= '0;
            r_pending    <= 1'b0;
        end else if (update_i && w_boundary) begin
            // A write landing on the boundary itself goes straight to the display
            r_shadow    <= value_i;
            r_shadow_en <= digit_en_i;
            r_pending   <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_shadow    <= r_staging;
                r_shadow_en <= r_staging_en;
                r_pending   <= 1'b0;
            end
            if (update_i) begin
                r_staging    <= value_i;
                r_staging_en <= digit_en_i;
                r_pending    <= 1'b1;
            end
        end
    end

    // Register the decoder nibble, anode select and end-of-frame pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            nibble_o     <= 4'h0;
            anode_no     <= '1;
            frame_done_o <= 1'b0;
        end else begin
            nibble_o     <= w_nibble;
            anode_no     <= w_anode_n;
            frame_done_o <= w_boundary;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_mux
//  Description : Directed self-checking bench for seg_scan_mux with
//                NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1 (16-cycle frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    localparam int c_num_digits = 4;
    localparam int c_refresh    = 4;
    localparam int c_guard      = 1;
    localparam int c_frame      = c_num_digits * c_refresh;

    logic        r_clk;
    logic        r_rst_n;
    logic [15:0] r_value;
    logic [3:0]  r_en;
    logic        r_update;
    logic [3:0]  w_nibble;
    logic [3:0]  w_anode_n;
    logic        w_frame_done;

    int n_checks;
    int n_errors;
    int cyc;   // cycles since reset release; outputs in cycle k reflect state k-1

    seg_scan_mux #(
        .NUM_DIGITS   (c_num_digits),
        .REFRESH_DIV  (c_refresh),
        .GUARD_CYCLES (c_guard)
    ) u_dut (
        .clk_i        (r_clk),
        .rst_ni       (r_rst_n),
        .value_i      (r_value),
        .digit_en_i   (r_en),
        .update_i     (r_update),
        .nibble_o     (w_nibble),
        .anode_no     (w_anode_n),
        .frame_done_o (w_frame_done)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and check outputs against the word/enables expected on screen
    task automatic step_check(input logic [15:0] word, input logic [3:0] en);
        int         j;
        int         s;
        int         t;
        logic [3:0] exp_an;
        logic [3:0] exp_nib;
        logic [3:0] one;
        @(posedge r_clk);
        cyc++;
        @(negedge r_clk);
        j       = (cyc - 1) % c_frame;
        s       = j / c_refresh;
        t       = j % c_refresh;
        one     = 4'b0001;
        exp_an  = (t < c_guard || !en[s]) ? 4'b1111 : ~(one << s);
        exp_nib = word[4*s +: 4];
        check($sformatf("anode k=%0d", cyc), 32'(w_anode_n), 32'(exp_an));
        check($sformatf("nibble k=%0d", cyc), 32'(w_nibble), 32'(exp_nib));
        check($sformatf("frame_done k=%0d", cyc), 32'(w_frame_done), (j == c_frame - 1) ? 32'd1 : 32'd0);
    endtask

    task automatic run_to(input int k, input logic [15:0] word, input logic [3:0] en);
        while (cyc < k) step_check(word, en);
    endtask

    // One-cycle update strobe; the cycle it spans is checked against the current display
    task automatic pulse_update(input logic [15:0] val, input logic [3:0] en_new,
                                input logic [15:0] shown, input logic [3:0] shown_en);
        r_value  = val;
        r_en     = en_new;
        r_update = 1'b1;
        step_check(shown, shown_en);
        r_update = 1'b0;
        // Junk on the data pins must be ignored while the strobe is low
        r_value  = 16'hEEEE;
        r_en     = 4'b0011;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        r_rst_n  = 1'b0;
        r_update = 1'b0;
        r_value  = 16'h0000;
        r_en     = 4'h0;

        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        check("reset anode", 32'(w_anode_n), 32'hF);
        check("reset nibble", 32'(w_nibble), 32'h0);
        check("reset frame_done", 32'(w_frame_done), 32'h0);
        r_rst_n = 1'b1;
        cyc     = 0;

        // Frame 0: blank display; stage 1234 mid-frame
        run_to(3, 16'h0000, 4'h0);
        pulse_update(16'h1234, 4'hF, 16'h0000, 4'h0);
        run_to(16, 16'h0000, 4'h0);

        // Frame 1: shows 1234; ABCD then 5678 staged, last write wins
        run_to(20, 16'h1234, 4'hF);
        pulse_update(16'hABCD, 4'hF, 16'h1234, 4'hF);
        run_to(25, 16'h1234, 4'hF);
        pulse_update(16'h5678, 4'hF, 16'h1234, 4'hF);
        run_to(32, 16'h1234, 4'hF);

        // Frame 2: shows 5678; stage FFFF with digits 1 and 3 blanked
        run_to(35, 16'h5678, 4'hF);
        pulse_update(16'hFFFF, 4'b0101, 16'h5678, 4'hF);
        run_to(48, 16'h5678, 4'hF);

        // Frame 3: partial enables; strobe lands exactly on the boundary cycle
        run_to(63, 16'hFFFF, 4'b0101);
        pulse_update(16'h2468, 4'hF, 16'hFFFF, 4'b0101);

        // Frame 4: boundary write visible at once; stage 1357 then reset
        run_to(68, 16'h2468, 4'hF);
        pulse_update(16'h1357, 4'hF, 16'h2468, 4'hF);
        run_to(70, 16'h2468, 4'hF);
        r_rst_n = 1'b0;
        @(posedge r_clk);
        @(negedge r_clk);
        check("midreset anode", 32'(w_anode_n), 32'hF);
        check("midreset nibble", 32'(w_nibble), 32'h0);
        check("midreset frame_done", 32'(w_frame_done), 32'h0);
        r_rst_n = 1'b1;
        cyc     = 0;

        // Two frames after reset: the discarded 1357 must never appear
        run_to(2 * c_frame, 16'h0000, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
